// File: rtl/cdb_pkg.sv
// Shared definitions for the result-broadcast block: default widths, entry/bus types
// and the fixed source priority order (mem first, then alu0, then alu1).
// Ports: none (package).
package cdb_pkg;

    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;

    // Source order used both for FIFO write compaction and for bypass slot filling.
    localparam int SRC_MEM  = 0;
    localparam int SRC_ALU0 = 1;
    localparam int SRC_ALU1 = 2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic              we;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_fifo_3w2r.sv
// Circular result buffer: up to 3 compacting writes and 0..2 reads per cycle.
// Latency: a write is visible at the head on the cycle after the edge that stores it.
// Backpressure: none internally; the caller guarantees free space before writing.
// Ports: CLK/reset (sync, active-high), flush empties the buffer, wr_vld/wr_tag/wr_dat
// per source in priority order, pop_cnt entries retired this edge, count occupancy,
// rd0_* head entry, rd1_* head+1 entry.
module cdb_fifo_3w2r #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = cdb_pkg::TAG_W,
    parameter int DATA_W = cdb_pkg::DATA_W
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [2:0]                      wr_vld,
    input  logic [2:0][TAG_W-1:0]           wr_tag,
    input  logic [2:0][DATA_W-1:0]          wr_dat,
    input  logic [1:0]                      pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic [TAG_W-1:0]                rd0_tag,
    output logic [DATA_W-1:0]               rd0_dat,
    output logic [TAG_W-1:0]                rd1_tag,
    output logic [DATA_W-1:0]               rd1_dat
);
    import cdb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  head_p1;
    logic [1:0]        push_cnt;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two, and the
    // increment never exceeds 3 < DEPTH, so a single conditional subtract wraps it.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0] inc);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + {{PTR_W{1'b0}}, inc};
        if (s >= (PTR_W+2)'(DEPTH)) begin
            s = s - (PTR_W+2)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        tag_d    = tag_q;
        data_d   = data_q;
        wptr     = tail_q;
        push_cnt = 2'd0;
        // Compaction: each valid source takes the next free slot, skipping idle ones.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wr_vld[k]) begin
                tag_d[wptr]  = wr_tag[k];
                data_d[wptr] = wr_dat[k];
                wptr         = ptr_add(wptr, 2'd1);
                push_cnt     = push_cnt + 2'd1;
            end
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, pop_cnt);
            tail_d  = wptr;
            count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign head_p1 = ptr_add(head_q, 2'd1);
    assign count   = count_q;
    assign rd0_tag = tag_q[head_q];
    assign rd0_dat = data_q[head_q];
    assign rd1_tag = tag_q[head_p1];
    assign rd1_dat = data_q[head_p1];

endmodule

// File: rtl/cdb_broadcaster.sv
// Result broadcaster: gathers mem/alu0/alu1 results and drives two registered CDB slots.
// Latency: 2 cycles through the FIFO; 1 cycle when built with CDB_BYPASS_EN (direct slot fill).
// Backpressure: in_ready from registered count only; valids seen while not ready are dropped
// and latch push_err until reset. ROBFlush empties everything and drops same-cycle inputs.
// Ports: CLK, reset (sync, active-high), ROBFlush, {mem,alu0,alu1}_{valid,tag,data},
// in_ready, WE1/WT1/WD1 and WE2/WT2/WD2 broadcast slots, count, push_err.
module cdb_broadcaster #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = cdb_pkg::TAG_W,
    parameter int DATA_W = cdb_pkg::DATA_W
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        ROBFlush,
    input  logic                        alu0_valid,
    input  logic [TAG_W-1:0]            alu0_tag,
    input  logic [DATA_W-1:0]           alu0_data,
    input  logic                        alu1_valid,
    input  logic [TAG_W-1:0]            alu1_tag,
    input  logic [DATA_W-1:0]           alu1_data,
    input  logic                        mem_valid,
    input  logic [TAG_W-1:0]            mem_tag,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        in_ready,
    output logic                        WE1,
    output logic [TAG_W-1:0]            WT1,
    output logic [DATA_W-1:0]           WD1,
    output logic                        WE2,
    output logic [TAG_W-1:0]            WT2,
    output logic [DATA_W-1:0]           WD2,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        push_err
);
    import cdb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_SRC-1:0]             raw_vld;
    logic [NUM_SRC-1:0]             src_vld;
    logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_dat;
    logic [NUM_SRC-1:0]             wr_vld;
    logic                           accept;
    logic [1:0]                     pop_cnt;

    logic [TAG_W-1:0]  rd0_tag, rd1_tag;
    logic [DATA_W-1:0] rd0_dat, rd1_dat;

    // Slot 0 drives WE1/WT1/WD1, slot 1 drives WE2/WT2/WD2.
    logic [1:0]             we_q, we_d;
    logic [1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [1:0][DATA_W-1:0] dat_q, dat_d;
    logic                   push_err_q, push_err_d;

`ifdef CDB_BYPASS_EN
    logic [1:0] used;
`endif

    assign raw_vld[SRC_MEM]  = mem_valid;
    assign raw_vld[SRC_ALU0] = alu0_valid;
    assign raw_vld[SRC_ALU1] = alu1_valid;
    assign src_tag[SRC_MEM]  = mem_tag;
    assign src_tag[SRC_ALU0] = alu0_tag;
    assign src_tag[SRC_ALU1] = alu1_tag;
    assign src_dat[SRC_MEM]  = mem_data;
    assign src_dat[SRC_ALU0] = alu0_data;
    assign src_dat[SRC_ALU1] = alu1_data;

    // Room for a worst-case 3-result cycle, judged on registered occupancy only.
    assign in_ready = (count <= CNT_W'(DEPTH - 3));

    always_comb begin
        accept  = in_ready & ~ROBFlush;
        src_vld = raw_vld & {NUM_SRC{accept}};

        if (ROBFlush) begin
            pop_cnt = 2'd0;
        end else if (count >= CNT_W'(2)) begin
            pop_cnt = 2'd2;
        end else begin
            pop_cnt = count[1:0];
        end

        we_d  = '0;
        tag_d = '0;
        dat_d = '0;
        if (pop_cnt != 2'd0) begin
            we_d[0]  = 1'b1;
            tag_d[0] = rd0_tag;
            dat_d[0] = rd0_dat;
        end
        if (pop_cnt == 2'd2) begin
            we_d[1]  = 1'b1;
            tag_d[1] = rd1_tag;
            dat_d[1] = rd1_dat;
        end

`ifdef CDB_BYPASS_EN
        // Slots left free by the pop can only exist when the FIFO drains fully this
        // edge, so giving them to new results keeps broadcast order equal to arrival.
        used   = pop_cnt;
        wr_vld = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_vld[k]) begin
                if (used < 2'd2) begin
                    we_d[used[0]]  = 1'b1;
                    tag_d[used[0]] = src_tag[k];
                    dat_d[used[0]] = src_dat[k];
                    used           = used + 2'd1;
                end else begin
                    wr_vld[k] = 1'b1;
                end
            end
        end
`else
        wr_vld = src_vld;
`endif

        // A flush cycle discards inputs silently; only a genuine overflow is an error.
        push_err_d = push_err_q | ((|raw_vld) & ~in_ready & ~ROBFlush);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            we_q       <= '0;
            tag_q      <= '0;
            dat_q      <= '0;
            push_err_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            tag_q      <= tag_d;
            dat_q      <= dat_d;
            push_err_q <= push_err_d;
        end
    end

    cdb_fifo_3w2r #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .flush   (ROBFlush),
        .wr_vld  (wr_vld),
        .wr_tag  (src_tag),
        .wr_dat  (src_dat),
        .pop_cnt (pop_cnt),
        .count   (count),
        .rd0_tag (rd0_tag),
        .rd0_dat (rd0_dat),
        .rd1_tag (rd1_tag),
        .rd1_dat (rd1_dat)
    );

    assign WE1      = we_q[0];
    assign WT1      = tag_q[0];
    assign WD1      = dat_q[0];
    assign WE2      = we_q[1];
    assign WT2      = tag_q[1];
    assign WD2      = dat_q[1];
    assign push_err = push_err_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        ROBFlush = 1'b0;
    logic        alu0_valid = 1'b0, alu1_valid = 1'b0, mem_valid = 1'b0;
    logic [3:0]  alu0_tag = '0, alu1_tag = '0, mem_tag = '0;
    logic [31:0] alu0_data = '0, alu1_data = '0, mem_data = '0;
    logic        in_ready, WE1, WE2, push_err;
    logic [3:0]  WT1, WT2, count;
    logic [31:0] WD1, WD2;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    cdb_broadcaster #(.DEPTH(8), .TAG_W(4), .DATA_W(32)) dut (
        .CLK(CLK), .reset(reset), .ROBFlush(ROBFlush),
        .alu0_valid(alu0_valid), .alu0_tag(alu0_tag), .alu0_data(alu0_data),
        .alu1_valid(alu1_valid), .alu1_tag(alu1_tag), .alu1_data(alu1_data),
        .mem_valid(mem_valid), .mem_tag(mem_tag), .mem_data(mem_data),
        .in_ready(in_ready),
        .WE1(WE1), .WT1(WT1), .WD1(WD1),
        .WE2(WE2), .WT2(WT2), .WD2(WD2),
        .count(count), .push_err(push_err)
    );

    // vld bit 0 = mem, bit 1 = alu0, bit 2 = alu1
    typedef struct {
        logic        rst, fl;
        logic [2:0]  vld;
        logic [3:0]  mt;  logic [31:0] md;
        logic [3:0]  a0t; logic [31:0] a0d;
        logic [3:0]  a1t; logic [31:0] a1d;
        logic        we1; logic [3:0] wt1; logic [31:0] wd1;
        logic        we2; logic [3:0] wt2; logic [31:0] wd2;
        logic [3:0]  cnt;
        logic        rdy, perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t r(input logic rst, input logic fl, input logic [2:0] vld,
                               input logic [3:0] mt, input logic [31:0] md,
                               input logic [3:0] a0t, input logic [31:0] a0d,
                               input logic [3:0] a1t, input logic [31:0] a1d,
                               input logic we1, input logic [3:0] wt1, input logic [31:0] wd1,
                               input logic we2, input logic [3:0] wt2, input logic [31:0] wd2,
                               input logic [3:0] cnt, input logic rdy, input logic perr);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld;
        v.mt = mt; v.md = md; v.a0t = a0t; v.a0d = a0d; v.a1t = a1t; v.a1d = a1d;
        v.we1 = we1; v.wt1 = wt1; v.wd1 = wd1;
        v.we2 = we2; v.wt2 = wt2; v.wd2 = wd2;
        v.cnt = cnt; v.rdy = rdy; v.perr = perr;
        return v;
    endfunction

    function automatic logic [31:0] dd(input int t);
        return 32'hD00 + 32'(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [2:0] vld,
                         input logic [3:0] mt, input logic [31:0] md,
                         input logic [3:0] a0t, input logic [31:0] a0d,
                         input logic [3:0] a1t, input logic [31:0] a1d);
        reset = rst; ROBFlush = fl;
        mem_valid = vld[0]; mem_tag = mt; mem_data = md;
        alu0_valid = vld[1]; alu0_tag = a0t; alu0_data = a0d;
        alu1_valid = vld[2]; alu1_tag = a1t; alu1_data = a1d;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] tg;
    logic [3:0] exp_cnt [4];
    logic       exp_rdy [4];

    task automatic score(input string nm);
        logic [3:0] e;
        chk({nm, ".we2_implies_we1"}, 32'(WE2 & ~WE1), 32'd0);
        if (WE1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
            chk({nm, ".wt1"}, 32'(WT1), 32'(e));
            chk({nm, ".wd1"}, WD1, 32'hC000 + 32'(e));
        end
        if (WE2) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
            chk({nm, ".wt2"}, 32'(WT2), 32'(e));
            chk({nm, ".wd2"}, WD2, 32'hC000 + 32'(e));
        end
    endtask

    initial begin
        // Single push, then a burst of three, idle drain.
        vecs.push_back(r(1,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b010, 0,0, 5,32'h1234, 0,0, 0,0,0,          0,0,0,          1,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,5,32'h1234,   0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b111, 1,32'hA, 2,32'hB, 3,32'hC, 0,0,0,     0,0,0,          3,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,1,32'hA,      1,2,32'hB,      1,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,3,32'hC,      0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));
        // Flush at count=4 with alu1 tag 9 presented.
        vecs.push_back(r(0,0,3'b111, 1,dd(1), 2,dd(2), 3,dd(3), 0,0,0,     0,0,0,          3,1,0));
        vecs.push_back(r(0,0,3'b111, 4,dd(4), 5,dd(5), 6,dd(6), 1,1,dd(1), 1,2,dd(2),      4,1,0));
        vecs.push_back(r(0,1,3'b100, 0,0, 0,0, 9,dd(9),    0,0,0,          0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));
        // Fill to count=6, overflow with mem tag 7, flush keeps push_err, reset clears.
        vecs.push_back(r(0,0,3'b111, 1,dd(1), 2,dd(2), 3,dd(3), 0,0,0,     0,0,0,          3,1,0));
        vecs.push_back(r(0,0,3'b111, 4,dd(4), 5,dd(5), 6,dd(6), 1,1,dd(1), 1,2,dd(2),      4,1,0));
        vecs.push_back(r(0,0,3'b111, 8,dd(8), 9,dd(9), 10,dd(10), 1,3,dd(3), 1,4,dd(4),    5,1,0));
        vecs.push_back(r(0,0,3'b111, 11,dd(11), 12,dd(12), 13,dd(13), 1,5,dd(5), 1,6,dd(6), 6,0,0));
        vecs.push_back(r(0,0,3'b001, 7,dd(7), 0,0, 0,0,    1,8,dd(8),      1,9,dd(9),      4,1,1));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,10,dd(10),    1,11,dd(11),    2,1,1));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,12,dd(12),    1,13,dd(13),    0,1,1));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,1));
        vecs.push_back(r(0,1,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,1));
        vecs.push_back(r(1,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));
        // Mid-operation reset at count=5 with both slots live, then a clean single push.
        vecs.push_back(r(0,0,3'b111, 1,dd(1), 2,dd(2), 3,dd(3), 0,0,0,     0,0,0,          3,1,0));
        vecs.push_back(r(0,0,3'b111, 4,dd(4), 5,dd(5), 6,dd(6), 1,1,dd(1), 1,2,dd(2),      4,1,0));
        vecs.push_back(r(0,0,3'b111, 8,dd(8), 9,dd(9), 10,dd(10), 1,3,dd(3), 1,4,dd(4),    5,1,0));
        vecs.push_back(r(1,0,3'b010, 0,0, 15,dd(15), 0,0,  0,0,0,          0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b010, 0,0, 5,32'h1234, 0,0, 0,0,0,          0,0,0,          1,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        1,5,32'h1234,   0,0,0,          0,1,0));
        vecs.push_back(r(0,0,3'b000, 0,0, 0,0, 0,0,        0,0,0,          0,0,0,          0,1,0));

        drive(1,0,3'b000, 0,0, 0,0, 0,0);
        tick;
        tick;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.fl, v.vld, v.mt, v.md, v.a0t, v.a0d, v.a1t, v.a1d);
            tick;
            chk($sformatf("v%0d.we1", i),  32'(WE1),      32'(v.we1));
            chk($sformatf("v%0d.wt1", i),  32'(WT1),      32'(v.wt1));
            chk($sformatf("v%0d.wd1", i),  WD1,           v.wd1);
            chk($sformatf("v%0d.we2", i),  32'(WE2),      32'(v.we2));
            chk($sformatf("v%0d.wt2", i),  32'(WT2),      32'(v.wt2));
            chk($sformatf("v%0d.wd2", i),  WD2,           v.wd2);
            chk($sformatf("v%0d.count", i), 32'(count),   32'(v.cnt));
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(v.rdy));
            chk($sformatf("v%0d.push_err", i), 32'(push_err), 32'(v.perr));
        end

        // Streaming: all three sources every cycle from empty until the FIFO fills.
        exp_cnt = '{4'd3, 4'd4, 4'd5, 4'd6};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        tg = 4'd0;
        chk("stream.start_count", 32'(count), 32'd0);
        for (int c = 0; c < 4; c++) begin
            drive(0,0,3'b111, tg, 32'hC000 + 32'(tg),
                  tg + 4'd1, 32'hC000 + 32'(tg + 4'd1),
                  tg + 4'd2, 32'hC000 + 32'(tg + 4'd2));
            exp_q.push_back(tg);
            exp_q.push_back(tg + 4'd1);
            exp_q.push_back(tg + 4'd2);
            tg = tg + 4'd3;
            tick;
            score($sformatf("stream%0d", c));
            chk($sformatf("stream%0d.count", c), 32'(count), 32'(exp_cnt[c]));
            chk($sformatf("stream%0d.in_ready", c), 32'(in_ready), 32'(exp_rdy[c]));
        end
        for (int c = 0; c < 5; c++) begin
            drive(0,0,3'b000, 0,0, 0,0, 0,0);
            tick;
            score($sformatf("drain%0d", c));
            if (c == 0) begin
                chk("drain0.count", 32'(count), 32'd4);
                chk("drain0.in_ready", 32'(in_ready), 32'd1);
            end
        end
        chk("stream.end_count", 32'(count), 32'd0);
        chk("stream.all_broadcast", 32'(exp_q.size()), 32'd0);
        chk("stream.push_err", 32'(push_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer side of the result-broadcast interface consumed by the reservation stations: drives WT1/WD1/WE1 and WT2/WD2/WE2.
- Collects completed results from ALU0, ALU1 and the memory unit, buffers them in a 3-write/2-read FIFO and broadcasts up to two tag/data pairs per cycle.
- Sits between the execution units and all RS/ROB listeners. Flushed by ROBFlush.

Parameters:
- DEPTH, 8, FIFO entries; must be >= 4.
- TAG_W, 4, ROB tag width.
- DATA_W, 32, result width.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high
- ROBFlush  in  1  discard all buffered and in-flight results
- alu0_valid / alu0_tag / alu0_data  in  1 / TAG_W / DATA_W  ALU0 result
- alu1_valid / alu1_tag / alu1_data  in  1 / TAG_W / DATA_W  ALU1 result
- mem_valid / mem_tag / mem_data  in  1 / TAG_W / DATA_W  memory-unit result
- in_ready  out  1  shared acceptance for all three sources
- WE1 / WT1 / WD1  out  1 / TAG_W / DATA_W  broadcast slot 1, registered
- WE2 / WT2 / WD2  out  1 / TAG_W / DATA_W  broadcast slot 2, registered
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- push_err  out  1  sticky: a valid was presented while in_ready=0

Behaviour:
- Reset:
  - count=0, FIFO empty, push_err=0.
  - WE1=WE2=0; WT1=WT2=0; WD1=WD2=0. Idle slots always drive tag/data 0, never X.
- in_ready = (DEPTH - count) >= 3. Derived combinationally from registered count only; no input-to-ready path.
- Push, per edge with in_ready=1:
  - Valid sources are written in fixed order mem, alu0, alu1 into consecutive tail slots.
  - Each source has at most one result per cycle.
- Pop, per edge:
  - pops = min(count, 2), using count before this edge.
  - The oldest entry loads slot 1 and the next oldest loads slot 2, with WE set.
  - Slots not loaded get WE=0 and tag/data 0.
  - Slot 1 is always filled before slot 2. WE2=1 implies WE1=1.
- Occupancy: count_next = count + pushes - pops. Push and pop in the same cycle are legal.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Latency (no macro): a result presented at edge N with an empty FIFO appears on a WE slot after edge N+1, i.e. 2 cycles.
- Ordering: broadcast order equals push order. No reordering and no duplicate broadcast of an entry.
- Overflow protection:
  - A valid presented while in_ready=0 is dropped and not written.
  - push_err is set and stays 1 until reset. ROBFlush does not clear it.
- ROBFlush=1 at edge N:
  - FIFO is emptied (count=0); WE1=WE2=0 and tag/data 0 after edge N.
  - Inputs presented in that cycle are dropped, with no push_err.
  - Flush overrides push and pop.
- Reset has priority over flush and takes effect mid-operation identically to power-up.
- Tags are opaque. Duplicate tags are broadcast as given and are not checked.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined: at edge N, incoming results that would fill broadcast slots left unused by FIFO pops load WE1/WE2 directly, in mem, alu0, alu1 order after the popped entries. Only the remainder is written to the FIFO.
  - Empty-FIFO latency becomes 1 cycle.
  - Ordering is still preserved.
  - count reflects only entries actually stored.
- Undefined: all results pass through the FIFO, with 2-cycle minimum latency as above.

Decomposition:
- Package cdb_pkg:
  - TAG_W and DATA_W constants.
  - Typedef cdb_entry_t {tag, data}.
  - Typedef cdb_bus_t {we, tag, data}.
  - Source-order constants SRC_MEM=0, SRC_ALU0=1, SRC_ALU1=2.
- One sub-module, cdb_fifo_3w2r:
  - Circular buffer with 3 compacting write ports and 2 read ports.
  - Outputs count and the head/head+1 entries.
- The top level holds the output registers, ready, push_err, flush and bypass logic.

Test Plan:
- After reset, alu0 pushes tag 5 / data 0x1234 for one cycle -> two edges later WE1=1, WT1=5, WD1=0x1234, WE2=0. One edge later with CDB_BYPASS_EN. Next cycle WE1=0.
- One cycle with mem (tag 1, 0xA), alu0 (tag 2, 0xB) and alu1 (tag 3, 0xC) all valid -> first broadcast cycle: slot1=tag 1, slot2=tag 2. Next cycle: slot1=tag 3, WE2=0. Then idle.
- All three sources valid every cycle from empty, DEPTH=8 -> count goes 0,3,4,5,6, then in_ready=0. After the next pop count=4 and in_ready=1 again. Broadcast tag sequence is strictly in push order.
- With count=4, assert ROBFlush alongside alu1 valid tag 9 -> next cycle count=0, WE1=WE2=0, in_ready=1, tag 9 never broadcast, push_err=0.
- With in_ready=0, present mem tag 7 -> push_err=1 and tag 7 never broadcast. A later ROBFlush leaves push_err=1. Reset clears it.
- Assert reset while count=5 and both slots active -> next cycle all outputs at reset values, count=0. A subsequent single push behaves exactly as in the first scenario.
